spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
Parametrised SPI slave running entirely in the system clock domain. SCLK, CS_N and MOSI are oversampled through synchronisers. The block supports all four SPI modes, configurable word width and bit order, and back-to-back words within one chip-select. Host logic talks to it through buffered valid/ready TX and RX interfaces with underrun and overrun reporting.

Parameters:
DATA_W, 8, word width in bits (>=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on sclk/cs_n/mosi (>=2)

Ports:
clk  in  1  system clock; must be at least 4x the SCLK frequency
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock (asynchronous)
cs_n  in  1  chip select, active low (asynchronous)
mosi  in  1  master-out serial data
miso  out  1  slave-out serial data
miso_oe  out  1  MISO output enable, high while selected
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid; held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  1-cycle pulse: an unaccepted RX word was overwritten
tx_underrun  out  1  1-cycle pulse: a word started with the TX holding register empty
busy  out  1  high while cs_n is synchronised-low

Behaviour:
- Reset (async assert, sync release): miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, tx_underrun=0, busy=0. Bit counter=0, state=IDLE, TX holding register empty.
- Synchronisers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. The edge detector compares the last two synchronised sclk samples.
- Edge definitions:
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing.
  - Shift edge = the other edge.
- State machine:
  - IDLE -> ACTIVE on the synchronised cs_n falling. This is a word start: load the shift register and drive miso_oe=1.
  - ACTIVE -> IDLE whenever synchronised cs_n is high, including mid-word.
- Word start (cs_n fall, or the cycle after a word completes while still ACTIVE):
  - If the holding register is full: copy it into the TX shift register and mark it empty.
  - Otherwise: load all zeros and pulse tx_underrun.
- CPHA=0: the first TX bit appears on miso in the cycle after the load. Subsequent bits change on shift edges.
- CPHA=1: miso shifts on every shift edge, including the first leading edge.
- Bit order: MSB_FIRST selects which end leaves on miso and which end mosi bits enter.
- Bit counter counts sample edges 0..DATA_W-1. On the DATA_W-th sample edge the counter wraps to 0 and the word completes.
- RX completion: in the clk cycle after the final sample strobe, rx_data <= assembled word and rx_valid <= 1.
  - If rx_valid was already 1 and rx_ready was 0 in that cycle: the old word is overwritten and rx_overrun pulses.
  - Accepting an old word in the same cycle a new word lands counts as no overrun.
- RX handshake: rx_valid clears on the cycle after rx_valid && rx_ready, unless a new word lands in that same cycle.
- TX handshake: the holding register loads on tx_valid && tx_ready, and tx_ready drops the next cycle.
  - A load and a consume in the same cycle are ordered consume first, then load. Net result: holding register full, tx_ready=0.
- cs_n rise mid-word:
  - Discard the partial RX word; no rx_valid.
  - Reset the bit counter.
  - miso_oe=0 and miso=0 the next cycle.
  - The TX holding register is left untouched.
  - SCLK edges while cs_n is high are ignored.
- Latency: pin edge to internal strobe is SYNC_STAGES+1 clk cycles; rx_valid rises one cycle after that.
- busy = 1 exactly while state==ACTIVE.
- Counter width: max(1, clog2(DATA_W)).

Test Plan:
1. Mode 0, DATA_W=8, MSB_FIRST: preload tx 0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid for one word; tx_underrun=0.
2. All four CPOL/CPHA combinations: master sends 0x96, slave sends 0x69 -> both sides receive the correct byte in every mode.
3. Back-to-back: three words 0x11, 0x22, 0x33 in one CS assertion; tx_valid offered at each tx_ready -> three rx_valid events in order. Holding 0xAA, 0xBB, then empty -> third word transmits 0x00 and tx_underrun pulses once.
4. Overrun: rx_ready held 0, two words 0x01 then 0x02 -> rx_data=0x02, rx_overrun pulses exactly once. Then with rx_ready=1 and a new word landing in the accept cycle -> no pulse.
5. Abort: cs_n rises after 5 bits of 0xF0 -> no rx_valid, miso_oe=0. The next full word 0x0F is received correctly, with the counter restarted at 0.
6. Reset mid-word: rst_n pulled low at bit 3 -> all outputs at reset values immediately. After release, a fresh transfer works; DATA_W=12, MSB_FIRST=0 variant with 0xABC round-trips.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave, fully in the clk domain: oversampled sclk/cs_n/mosi, all four modes,
// back-to-back words per chip-select, buffered valid/ready TX and RX sides.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int   CW       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_p;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   lead_e, trail_e, sel, sample_stb, shift_stb, last_bit, cs_drop;
  logic                   word_start, done_q, hold_full, udr_pend;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_W-1:0]      hold_data, tx_sr, rx_sr, ld_word;

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] out_shift(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_p    <= IDLE_LVL;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_p    <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign lead_e   = (sclk_s != IDLE_LVL) && (sclk_p == IDLE_LVL);
  assign trail_e  = (sclk_s == IDLE_LVL) && (sclk_p != IDLE_LVL);
  assign sel      = (state_q == ACTIVE) && !cs_s;
  assign cs_drop  = (state_q == ACTIVE) && cs_s;
  assign last_bit = (bit_cnt == CW'(DATA_W - 1));
  assign sample_stb = sel && ((CPHA != 0) ? trail_e : lead_e);
  // CPHA=0: the trailing edge that closes the previous word must not shift out
  // the first bit of the freshly loaded one.
  assign shift_stb  = sel && ((CPHA != 0) ? lead_e : (trail_e && (bit_cnt != '0)));
  assign ld_word  = hold_full ? hold_data : '0;
  assign tx_ready = !hold_full;
  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    case (state_q)
      IDLE: if (!cs_s) begin
        state_d    = ACTIVE;
        word_start = 1'b1;
      end
      ACTIVE: begin
        if (cs_s)        state_d    = IDLE;
        else if (done_q) word_start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso        <= 1'b0;
      bit_cnt     <= '0;
      done_q      <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      udr_pend    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      done_q      <= sample_stb && last_bit;

      if (cs_drop) begin
        bit_cnt  <= '0;
        miso     <= 1'b0;
        udr_pend <= 1'b0;
      end else begin
        if (sample_stb) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
          rx_sr   <= (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], mosi_s}
                                      : {mosi_s, rx_sr[DATA_W-1:1]};
          // An empty-load only counts as an underrun once the master clocks that word.
          if (bit_cnt == '0 && udr_pend) begin
            tx_underrun <= 1'b1;
            udr_pend    <= 1'b0;
          end
        end
        if (word_start) begin
          udr_pend <= !hold_full;
          if (CPHA == 0) begin
            miso  <= out_bit(ld_word);
            tx_sr <= out_shift(ld_word);
          end else begin
            tx_sr <= ld_word;
          end
        end else if (shift_stb) begin
          miso  <= out_bit(tx_sr);
          tx_sr <= out_shift(tx_sr);
        end
      end

      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (word_start) begin
        hold_full <= 1'b0;
      end

      if (done_q) begin
        rx_data    <= rx_sr;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// Five slaves (modes 0..3 at 8 bits MSB-first, plus 12-bit LSB-first mode 0) driven
// one at a time by a bit-banged master; received words go through a scoreboard queue.
`timescale 1ns/1ps
module tb_spi_slave_core;
  localparam int HALF = 8;
  localparam int NDUT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NDUT-1:0] sclk, cs_n, mosi, tx_valid, rx_ready;
  wire  [NDUT-1:0] miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy;
  logic [15:0] tx_data_w [NDUT];
  wire  [15:0] rx_data_w [NDUT];

  typedef struct {int d; logic [15:0] v;} exp_t;
  exp_t exp_q[$];

  int checks = 0, fails = 0, mchecks = 0, mfails = 0, n_ovr = 0, n_udr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    wire [7:0] rxd;
    spi_slave_core #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data_w[g][7:0]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .rx_data(rxd), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .rx_overrun(rx_overrun[g]), .tx_underrun(tx_underrun[g]), .busy(busy[g]));
    assign rx_data_w[g] = {8'h00, rxd};
  end

  wire [11:0] rxd12;
  spi_slave_core #(.DATA_W(12), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[4]), .cs_n(cs_n[4]), .mosi(mosi[4]),
    .miso(miso[4]), .miso_oe(miso_oe[4]), .tx_data(tx_data_w[4][11:0]), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .rx_data(rxd12), .rx_valid(rx_valid[4]), .rx_ready(rx_ready[4]),
    .rx_overrun(rx_overrun[4]), .tx_underrun(tx_underrun[4]), .busy(busy[4]));
  assign rx_data_w[4] = {4'h0, rxd12};

  function automatic logic f_cpol(input int d); return (d == 2 || d == 3); endfunction
  function automatic logic f_cpha(input int d); return (d == 1 || d == 3); endfunction
  function automatic int   f_w(input int d);    return (d == 4) ? 12 : 8;   endfunction
  function automatic logic f_msb(input int d);  return (d != 4);            endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic tx_push(input int d, input logic [15:0] v);
    int n;
    n = 0;
    while (!tx_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[d]) begin
      checks++;
      fails++;
      $display("FAIL tx_ready_wait dut%0d: tx_ready stayed 0, want 1", d);
    end
    tx_data_w[d] = v;
    tx_valid[d]  = 1'b1;
    @(negedge clk);
    tx_valid[d]  = 1'b0;
  endtask

  task automatic cs_begin(input int d);
    @(negedge clk);
    cs_n[d] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end(input int d);
    repeat (HALF) @(negedge clk);
    cs_n[d] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // late_rdy raises rx_ready exactly in the cycle the last bit's word lands (mode 0 only)
  task automatic xfer(input int d, input logic [15:0] mo, input int nbits, input bit late_rdy,
                      output logic [15:0] mi);
    logic idle_l;
    int w, b;
    idle_l = f_cpol(d);
    w = f_w(d);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      b = f_msb(d) ? (w - 1 - i) : i;
      if (!f_cpha(d)) begin
        mosi[d] = mo[b];
        repeat (HALF) @(negedge clk);
        sclk[d] = ~idle_l;
        mi[b] = miso[d];
        if (late_rdy && i == nbits - 1) begin
          repeat (3) @(negedge clk);
          rx_ready[d] = 1'b1;
          repeat (HALF - 3) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        sclk[d] = idle_l;
      end else begin
        sclk[d] = ~idle_l;
        mosi[d] = mo[b];
        repeat (HALF) @(negedge clk);
        sclk[d] = idle_l;
        mi[b] = miso[d];
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  // Monitor: every accepted RX word is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        for (int d = 0; d < NDUT; d++) begin
          if (rx_overrun[d])  n_ovr++;
          if (tx_underrun[d]) n_udr++;
          if (rx_valid[d] && rx_ready[d]) begin
            mchecks++;
            if (exp_q.size() == 0) begin
              mfails++;
              $display("FAIL rx_word dut%0d: got %0h, want no word", d, rx_data_w[d]);
            end else begin
              e = exp_q.pop_front();
              if (e.d != d || rx_data_w[d] !== e.v) begin
                mfails++;
                $display("FAIL rx_word dut%0d: got %0h, want %0h on dut%0d", d, rx_data_w[d], e.v, e.d);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mi;
    int c0;
    sclk = 5'b01100;
    cs_n = '1;
    mosi = '0;
    tx_valid = '0;
    rx_ready = '1;
    for (int d = 0; d < NDUT; d++) tx_data_w[d] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {miso, miso_oe, rx_valid, rx_overrun, tx_underrun, busy}, 32'h0);
    chk("rst_tx_ready", tx_ready, 32'h1f);
    chk("rst_rx_data", {rx_data_w[0], rx_data_w[4]}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: mode 0 basic word
    c0 = n_udr;
    tx_push(0, 16'hA5);
    chk("t1_tx_ready_full", tx_ready[0], 0);
    push_exp(0, 16'h3C);
    cs_begin(0);
    chk("t1_busy_oe", {busy[0], miso_oe[0]}, 2'b11);
    xfer(0, 16'h3C, 8, 1'b0, mi);
    chk("t1_miso", mi, 16'hA5);
    cs_end(0);
    chk("t1_underrun", n_udr - c0, 0);
    chk("t1_idle", {busy[0], miso_oe[0]}, 0);
    chk("t1_drain", exp_q.size(), 0);

    // 2: all four modes
    for (int d = 0; d < 4; d++) begin
      c0 = n_udr;
      tx_push(d, 16'h69);
      push_exp(d, 16'h96);
      cs_begin(d);
      xfer(d, 16'h96, 8, 1'b0, mi);
      cs_end(d);
      chk($sformatf("t2_miso_mode%0d", d), mi, 16'h69);
      chk($sformatf("t2_underrun_mode%0d", d), n_udr - c0, 0);
    end
    chk("t2_drain", exp_q.size(), 0);

    // 3: back-to-back, third word underruns
    c0 = n_udr;
    tx_push(0, 16'hAA);
    push_exp(0, 16'h11);
    push_exp(0, 16'h22);
    push_exp(0, 16'h33);
    cs_begin(0);
    tx_push(0, 16'hBB);
    xfer(0, 16'h11, 8, 1'b0, mi);
    chk("t3_miso_w0", mi, 16'hAA);
    xfer(0, 16'h22, 8, 1'b0, mi);
    chk("t3_miso_w1", mi, 16'hBB);
    xfer(0, 16'h33, 8, 1'b0, mi);
    chk("t3_miso_w2", mi, 16'h00);
    cs_end(0);
    chk("t3_underrun", n_udr - c0, 1);
    chk("t3_drain", exp_q.size(), 0);

    // 4: overrun, then accept in the landing cycle
    c0 = n_ovr;
    rx_ready[0] = 1'b0;
    push_exp(0, 16'h02);
    cs_begin(0);
    xfer(0, 16'h01, 8, 1'b0, mi);
    xfer(0, 16'h02, 8, 1'b0, mi);
    cs_end(0);
    chk("t4_overrun", n_ovr - c0, 1);
    chk("t4_rx_data", rx_data_w[0], 16'h02);
    rx_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready[0] = 1'b0;
    c0 = n_ovr;
    push_exp(0, 16'h03);
    push_exp(0, 16'h04);
    cs_begin(0);
    xfer(0, 16'h03, 8, 1'b0, mi);
    xfer(0, 16'h04, 8, 1'b1, mi);
    cs_end(0);
    chk("t4_no_overrun", n_ovr - c0, 0);
    chk("t4_drain", exp_q.size(), 0);

    // 5: abort after 5 bits
    cs_begin(0);
    xfer(0, 16'hF0, 5, 1'b0, mi);
    cs_end(0);
    chk("t5_abort_pins", {miso_oe[0], miso[0], rx_valid[0], busy[0]}, 0);
    push_exp(0, 16'h0F);
    cs_begin(0);
    xfer(0, 16'h0F, 8, 1'b0, mi);
    cs_end(0);
    chk("t5_drain", exp_q.size(), 0);

    // 6: reset mid-word, then 12-bit LSB-first round-trip
    cs_begin(4);
    xfer(4, 16'h0ABC, 3, 1'b0, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pins", {miso[4], miso_oe[4], rx_valid[4], rx_overrun[4], tx_underrun[4], busy[4]}, 0);
    chk("t6_rst_tx_ready", tx_ready[4], 1);
    chk("t6_rst_rx_data", rx_data_w[4], 0);
    cs_n[4] = 1'b1;
    sclk[4] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_push(4, 16'h05A3);
    push_exp(4, 16'h0ABC);
    cs_begin(4);
    xfer(4, 16'h0ABC, 12, 1'b0, mi);
    cs_end(4);
    chk("t6_miso", mi, 16'h05A3);
    chk("t6_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", (checks + mchecks) - (fails + mfails), checks + mchecks);
    $finish;
  end
endmodule
